// File: rtl/debounced_input_pio_if.sv
// Avalon-MM slave bus for the debounced input PIO: word-addressed, fixed read latency 1.
interface debounced_input_pio_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/debounced_input_pio.sv
// Synchronises and debounces WIDTH mechanical inputs, latches selected edges and
// raises a maskable level interrupt; CPU access over an Avalon-MM slave.
module debounced_input_pio #(
  parameter int unsigned      WIDTH           = 10,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [WIDTH-1:0]     in_export,
  debounced_input_pio_if.slave avs,
  output logic                 irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_IRQMASK = 2'd1,
    REG_EDGECAP = 2'd2,
    REG_RAW     = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  reg_addr_e        addr;
  logic             wr_irqmask;
  logic             wr_edgecap;
  logic             unused_wdata;

  assign sync_out     = sync_q[SYNC_STAGES-1];
  assign addr         = reg_addr_e'(avs.avs_address);
  assign wr_irqmask   = avs.avs_write && (addr == REG_IRQMASK);
  assign wr_edgecap   = avs.avs_write && (addr == REG_EDGECAP);
  assign unused_wdata = ^avs.avs_writedata;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    update   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync_out[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync_out[i];
        cnt_d[i]    = '0;
        update[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Capture happens on the same edge that moves the stable state.
  always_comb begin
    edge_set = '0;
    if (EDGE_MODE == 0)      edge_set = update & stable_d;
    else if (EDGE_MODE == 1) edge_set = update & ~stable_d;
    else                     edge_set = update;
  end

  // A software clear and a hardware set on the same bit in one cycle: set wins.
  always_comb begin
    edge_clr  = wr_edgecap ? avs.avs_writedata[WIDTH-1:0] : '0;
    edgecap_d = (edgecap_q & ~edge_clr) | edge_set;
    irqmask_d = wr_irqmask ? avs.avs_writedata[WIDTH-1:0] : irqmask_q;
  end

  // Reads sample the registers before any same-cycle write lands.
  always_comb begin
    readdata_d = readdata_q;
    if (avs.avs_read) begin
      case (addr)
        REG_DATA:    readdata_d = 32'(stable_q);
        REG_IRQMASK: readdata_d = 32'(irqmask_q);
        REG_EDGECAP: readdata_d = 32'(edgecap_q);
        REG_RAW:     readdata_d = 32'(sync_out);
        default:     readdata_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      // NOTE: the synchroniser and counter arrays are reset element by element so no partial count survives a reset.
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= RESET_VALUE;
      for (int i = 0; i < int'(WIDTH); i++)       cnt_q[i]  <= '0;
      stable_q   <= RESET_VALUE;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync_q[0] <= in_export;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign irq              = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_debounced_input_pio.sv
// Directed bench for debounced_input_pio: four instances (rising, reset-high, falling, both edges)
// share one Avalon bus; expected values are hand-derived from the debounce timing.
module tb_debounced_input_pio;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  pins;
  logic [3:0]  pins_rv;
  logic [1:0]  b_addr;
  logic        b_read;
  logic        b_write;
  logic [31:0] b_wdata;
  logic        irq0, irq_rv, irq_f, irq_b;
  logic        p_hist [40];

  int total = 0;
  int bad   = 0;

  debounced_input_pio_if bus0 ();
  debounced_input_pio_if bus_rv ();
  debounced_input_pio_if bus_f ();
  debounced_input_pio_if bus_b ();

  assign bus0.avs_address   = b_addr;
  assign bus0.avs_read      = b_read;
  assign bus0.avs_write     = b_write;
  assign bus0.avs_writedata = b_wdata;
  assign bus_rv.avs_address   = b_addr;
  assign bus_rv.avs_read      = b_read;
  assign bus_rv.avs_write     = b_write;
  assign bus_rv.avs_writedata = b_wdata;
  assign bus_f.avs_address   = b_addr;
  assign bus_f.avs_read      = b_read;
  assign bus_f.avs_write     = b_write;
  assign bus_f.avs_writedata = b_wdata;
  assign bus_b.avs_address   = b_addr;
  assign bus_b.avs_read      = b_read;
  assign bus_b.avs_write     = b_write;
  assign bus_b.avs_writedata = b_wdata;

  debounced_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2), .EDGE_MODE(0), .RESET_VALUE(4'h0))
    dut0 (.clk_clk(clk), .reset_reset_n(rst_n), .in_export(pins), .avs(bus0), .irq(irq0));
  debounced_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2), .EDGE_MODE(0), .RESET_VALUE(4'hF))
    dut_rv (.clk_clk(clk), .reset_reset_n(rst_n), .in_export(pins_rv), .avs(bus_rv), .irq(irq_rv));
  debounced_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2), .EDGE_MODE(1), .RESET_VALUE(4'h0))
    dut_f (.clk_clk(clk), .reset_reset_n(rst_n), .in_export(pins), .avs(bus_f), .irq(irq_f));
  debounced_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2), .EDGE_MODE(2), .RESET_VALUE(4'h0))
    dut_b (.clk_clk(clk), .reset_reset_n(rst_n), .in_export(pins), .avs(bus_b), .irq(irq_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    b_addr  = addr;
    b_wdata = data;
    b_write = 1'b1;
    tick();
    b_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr);
    b_addr = addr;
    b_read = 1'b1;
    tick();
    b_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    pins    = 4'h0;
    pins_rv = 4'hF;
    b_addr  = 2'd0;
    b_read  = 1'b0;
    b_write = 1'b0;
    b_wdata = '0;

    // Reset state
    #12;
    check("rst_rdata0", bus0.avs_readdata, 32'h0);
    check("rst_rdata_rv", bus_rv.avs_readdata, 32'h0);
    check("rst_irq", {28'h0, irq0, irq_rv, irq_f, irq_b}, 32'h0);
    tick();
    rst_n = 1'b1;

    // 1: reset-high instance sees no edge at release, even with all interrupts unmasked
    wr(2'd1, 32'hF);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rv_irq_quiet", {31'h0, irq_rv}, 32'h0);
    end
    rd(2'd0);
    check("rv_data", bus_rv.avs_readdata, 32'hF);
    rd(2'd3);
    check("rv_raw", bus_rv.avs_readdata, 32'hF);
    rd(2'd2);
    check("rv_edgecap", bus_rv.avs_readdata, 32'h0);
    wr(2'd1, 32'h1);

    // 2: pin0 step, capture exactly at edge 9
    pins[0] = 1'b1;
    repeat (9) tick();
    check("step_irq_edge8", {31'h0, irq0}, 32'h0);
    tick();
    check("step_irq_edge9", {31'h0, irq0}, 32'h1);
    rd(2'd0);
    check("step_data", bus0.avs_readdata, 32'h1);
    rd(2'd2);
    check("step_edgecap", bus0.avs_readdata, 32'h1);

    // 3: pin1 glitch train is rejected; RAW tracks the pin two edges late
    b_addr = 2'd3;
    b_read = 1'b1;
    for (int i = 0; i < 40; i++) begin
      p_hist[i] = ((i % 3) != 2);
      pins[1]   = p_hist[i];
      tick();
      if (i >= 2) check("raw_lag", {31'h0, bus0.avs_readdata[1]}, {31'h0, p_hist[i-2]});
    end
    b_read  = 1'b0;
    pins[1] = 1'b0;
    repeat (20) tick();
    rd(2'd0);
    check("glitch_data", bus0.avs_readdata, 32'h1);
    rd(2'd2);
    check("glitch_edgecap", bus0.avs_readdata, 32'h1);
    b_addr = 2'd0;
    repeat (3) tick();
    check("rdata_hold", bus0.avs_readdata, 32'h1);

    // 4: write-1-to-clear, then clear colliding with a fresh capture
    check("clr_irq_before", {31'h0, irq0}, 32'h1);
    wr(2'd2, 32'h1);
    check("clr_irq_after", {31'h0, irq0}, 32'h0);
    rd(2'd2);
    check("clr_edgecap", bus0.avs_readdata, 32'h0);
    pins[0] = 1'b0;
    repeat (15) tick();
    pins[0] = 1'b1;
    repeat (9) tick();
    check("collide_irq_pre", {31'h0, irq0}, 32'h0);
    b_addr  = 2'd2;
    b_wdata = 32'h1;
    b_write = 1'b1;
    tick();
    b_write = 1'b0;
    check("collide_irq", {31'h0, irq0}, 32'h1);
    rd(2'd2);
    check("collide_edgecap", bus0.avs_readdata, 32'h1);

    // Masking, read-during-write, unimplemented bits, read-only DATA
    wr(2'd1, 32'h0);
    check("mask_irq", {31'h0, irq0}, 32'h0);
    rd(2'd2);
    check("mask_keeps_cap", bus0.avs_readdata, 32'h1);
    b_addr  = 2'd1;
    b_wdata = 32'h3;
    b_write = 1'b1;
    b_read  = 1'b1;
    tick();
    b_write = 1'b0;
    b_read  = 1'b0;
    check("rw_same_cycle", bus0.avs_readdata, 32'h0);
    rd(2'd1);
    check("rw_new_mask", bus0.avs_readdata, 32'h3);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1);
    check("mask_upper_zero", bus0.avs_readdata, 32'hF);
    check("unmask_irq", {31'h0, irq0}, 32'h1);
    wr(2'd0, 32'h0);
    rd(2'd0);
    check("data_ro", bus0.avs_readdata, 32'h1);

    // 5: edge selection across the three edge modes on pin2
    wr(2'd2, 32'hF);
    pins[2] = 1'b1;
    repeat (20) tick();
    rd(2'd2);
    check("rise_mode0", bus0.avs_readdata, 32'h4);
    check("rise_mode1", bus_f.avs_readdata, 32'h0);
    check("rise_mode2", bus_b.avs_readdata, 32'h4);
    wr(2'd2, 32'h4);
    pins[2] = 1'b0;
    repeat (20) tick();
    rd(2'd2);
    check("fall_mode0", bus0.avs_readdata, 32'h0);
    check("fall_mode1", bus_f.avs_readdata, 32'h4);
    check("fall_mode2", bus_b.avs_readdata, 32'h4);

    // 6: reset while pin3's counter sits at 5, then a full fresh count
    pins[3] = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", bus0.avs_readdata, 32'h0);
    check("midrst_irq", {31'h0, irq0}, 32'h0);
    tick();
    tick();
    rst_n  = 1'b1;
    b_addr = 2'd0;
    b_read = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k <= 10) check("midrst_hold", {31'h0, bus0.avs_readdata[3]}, 32'h0);
      else         check("midrst_update", {31'h0, bus0.avs_readdata[3]}, 32'h1);
    end
    b_read = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounced_input_pio.md
Name: debounced_input_pio

Overview:
Parametrised successor to the plain button/switch PIO inputs on the Nios II system. It synchronises and debounces up to 32 mechanical inputs, captures edges selected by EDGE_MODE, and raises a maskable interrupt. The CPU accesses it through an Avalon-MM slave with fixed read latency 1. One instance replaces each raw PIO, e.g. WIDTH=4 for buttons and WIDTH=10 for switches.

Parameters:
WIDTH, 10, number of input channels (1..32)
DEBOUNCE_CYCLES, 500000, consecutive differing cycles before the stable state updates (>=1; 10 ms at 50 MHz)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
EDGE_MODE, 0, edge type captured: 0 rising, 1 falling, 2 both
RESET_VALUE, 0, WIDTH-bit reset value of the synchroniser chain and stable state (all-ones for active-low buttons)

Ports:
clk_clk  input  1  system clock
reset_reset_n  input  1  asynchronous, active-low reset
in_export  input  WIDTH  raw asynchronous pins
avs_address  input  2  register select
avs_read  input  1  read strobe
avs_write  input  1  write strobe
avs_writedata  input  32  write data
avs_readdata  output  32  read data, valid one cycle after avs_read
irq  output  1  level interrupt, |(edgecap & irqmask)

Behaviour:
- Reset (asynchronous, active-low): synchroniser chain = RESET_VALUE; stable = RESET_VALUE; all counters = 0; irqmask = 0; edgecap = 0; avs_readdata = 0; irq = 0. No edge is captured at reset release.
- Synchroniser: SYNC_STAGES flops per channel. sync_out = the last stage.
- Debounce, per channel:
  - if sync_out == stable: counter <= 0.
  - else if counter == DEBOUNCE_CYCLES-1: stable <= sync_out; counter <= 0.
  - else: counter++.
  - Counter width = clog2(DEBOUNCE_CYCLES), minimum 1.
  - A single agreeing cycle restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency: a clean pin step sampled at edge 0 reaches stable at edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - DEBOUNCE_CYCLES=1 degenerates to the synchroniser plus one register stage.
- Edge capture:
  - edgecap[i] is set on the same edge that updates stable[i], when the transition matches EDGE_MODE.
  - Bits stay set until cleared by software.
- Register map (word addresses):
  - 0 DATA, read-only: stable.
  - 1 IRQMASK, read/write: bits [WIDTH-1:0].
  - 2 EDGECAP, write-1-to-clear: write data bit i = 1 clears edgecap[i]. If a set and a clear of the same bit occur in the same cycle, the set wins.
  - 3 RAW, read-only: sync_out.
- Bus rules:
  - Unimplemented upper bits read as 0.
  - Writes to addresses 0 and 3 are ignored.
  - avs_readdata updates only in the cycle after avs_read and holds its value otherwise.
  - Read and write in the same cycle: the write takes effect and the read returns the pre-write value.
- irq is combinational from the registered edgecap and irqmask. Writing IRQMASK=0 deasserts irq in the next cycle without clearing edgecap.
- Reset asserted mid-debounce: all state returns to its reset values immediately; no partial count is retained.

Test Plan:
Bench configuration: WIDTH=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, EDGE_MODE=0 unless stated.
1. Reset with RESET_VALUE=4'hF, hold pins at 4'hF, release -> DATA=0xF, RAW=0xF, EDGECAP=0, irq=0 for at least 20 cycles.
2. RESET_VALUE=0, IRQMASK=0x1, pin0 step 0->1 at edge 0 -> DATA=0x1 and EDGECAP=0x1 at edge 9, irq=1 at edge 9.
3. Pin1 toggles with a 3-cycle period for 40 cycles, then returns to 0 -> DATA[1] stays 0, EDGECAP[1] stays 0, RAW[1] follows the pin with 2-cycle lag.
4. With EDGECAP=0x1 and irq=1, write 0x1 to address 2 -> EDGECAP=0 and irq=0 next cycle. Repeat with the clear landing on the same cycle as a new capture on pin0 -> EDGECAP stays 0x1.
5. EDGE_MODE=0: drive pin2 0->1->0 with 20-cycle holds -> EDGECAP=0x4 after rise only. EDGE_MODE=1 -> captures fall only. EDGE_MODE=2 -> captures both, clearing between edges.
6. Pin3 step, assert reset when counter=5, release -> DATA[3]=RESET_VALUE[3]; stable updates exactly 9 cycles after release while the pin is held, no earlier.
